// File: rtl/fft_sched_pkg.sv
// Shared types and address helper for the radix-2 DIT FFT stage scheduler.
// bf_addr() maps (stage, butterfly index) to the in-place operand pair and twiddle index.
package fft_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        FIN
    } state_e;

    localparam int unsigned ADDR_MAXW = 16;

    typedef struct packed {
        logic [ADDR_MAXW-1:0] addr_a;
        logic [ADDR_MAXW-1:0] addr_b;
        logic [ADDR_MAXW-1:0] tw_idx;
    } bf_addr_t;

    function automatic bf_addr_t bf_addr(input int unsigned log2n,
                                         input int unsigned s,
                                         input int unsigned k);
        int unsigned half;
        int unsigned pos;
        int unsigned a;
        bf_addr_t    r;
        half     = 32'd1 << s;
        pos      = k & (half - 32'd1);
        a        = ((k >> s) << (s + 32'd1)) | pos;
        r.addr_a = ADDR_MAXW'(a);
        r.addr_b = ADDR_MAXW'(a | half);
        r.tw_idx = ADDR_MAXW'(pos << (log2n - 32'd1 - s));
        return r;
    endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// Combinational butterfly address generator: (stage, k) -> addr_a, addr_b, tw_idx.
// Outputs are registered by the scheduler FSM.
module fft_addr_gen
    import fft_sched_pkg::*;
#(
    parameter int unsigned LOG2N = 3
) (
    input  logic [$clog2(LOG2N)-1:0] s,
    input  logic [LOG2N-2:0]         k,
    output logic [LOG2N-1:0]         addr_a,
    output logic [LOG2N-1:0]         addr_b,
    output logic [LOG2N-2:0]         tw_idx
);

    bf_addr_t r;
    logic     unused_hi;

    always_comb r = bf_addr(LOG2N, 32'(s), 32'(k));

    assign addr_a = r.addr_a[LOG2N-1:0];
    assign addr_b = r.addr_b[LOG2N-1:0];
    assign tw_idx = r.tw_idx[LOG2N-2:0];

    // Upper bits of the generic-width helper result are always zero here.
    assign unused_hi = ^{r.addr_a[ADDR_MAXW-1:LOG2N], r.addr_b[ADDR_MAXW-1:LOG2N],
                         r.tw_idx[ADDR_MAXW-1:LOG2N-1]};

endmodule

// File: rtl/fft_stage_scheduler.sv
// Radix-2 DIT FFT stage/butterfly sequencer with outstanding-op tracking and stage drain.
// Optional abort support is enabled by defining FFT_SCHED_ABORT_EN.
module fft_stage_scheduler
    import fft_sched_pkg::*;
#(
    parameter int unsigned LOG2N     = 3,
    parameter int unsigned MAX_OUTST = 4
) (
    input  logic                     Clock,
    input  logic                     nReset,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic                     bf_valid,
    input  logic                     bf_ready,
    input  logic                     bf_done,
    output logic [LOG2N-1:0]         addr_a,
    output logic [LOG2N-1:0]         addr_b,
    output logic [LOG2N-2:0]         tw_idx,
    output logic [$clog2(LOG2N)-1:0] stage
`ifdef FFT_SCHED_ABORT_EN
    ,
    input  logic                     abort,
    output logic                     aborted
`endif
);

    localparam int unsigned HALF_N  = 1 << (LOG2N - 1);
    localparam int unsigned STAGE_W = $clog2(LOG2N);
    localparam int unsigned KW      = LOG2N - 1;
    localparam int unsigned OW      = $clog2(MAX_OUTST + 1);

    localparam logic [KW-1:0]      K_LAST    = KW'(HALF_N - 1);
    localparam logic [STAGE_W-1:0] S_LAST    = STAGE_W'(LOG2N - 1);
    localparam logic [OW-1:0]      OUTST_MAX = OW'(MAX_OUTST);

    state_e             state;
    state_e             state_nxt;
    logic [KW-1:0]      k;
    logic [KW-1:0]      k_nxt;
    logic [STAGE_W-1:0] s_nxt;
    logic [OW-1:0]      outst;
    logic [OW-1:0]      outst_nxt;
    logic               issue;
    logic               spurious;
    logic               err_nxt;
    logic               aborting;
    logic               aborting_nxt;
    logic               abort_req;
    logic [LOG2N-1:0]   a_nxt;
    logic [LOG2N-1:0]   b_nxt;
    logic [LOG2N-2:0]   tw_nxt;

`ifdef FFT_SCHED_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // Addresses are computed from next-state (s, k) so the registered outputs line up with bf_valid.
    fft_addr_gen #(
        .LOG2N(LOG2N)
    ) u_addr_gen (
        .s     (s_nxt),
        .k     (k_nxt),
        .addr_a(a_nxt),
        .addr_b(b_nxt),
        .tw_idx(tw_nxt)
    );

    always_comb begin
        issue        = bf_valid && bf_ready;
        spurious     = bf_done && (outst == '0);
        state_nxt    = state;
        s_nxt        = stage;
        k_nxt        = k;
        aborting_nxt = aborting;
        err_nxt      = err || spurious;
        outst_nxt    = outst + OW'(issue) - OW'(bf_done && !spurious);

        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = ISSUE;
                    s_nxt     = '0;
                    k_nxt     = '0;
                    err_nxt   = spurious;
                end
            end
            ISSUE: begin
                if (issue) begin
                    if (k == K_LAST) state_nxt = DRAIN;
                    else             k_nxt     = k + 1'b1;
                end
                if (abort_req) begin
                    aborting_nxt = 1'b1;
                    state_nxt    = DRAIN;
                end
            end
            DRAIN: begin
                if (abort_req) aborting_nxt = 1'b1;
                if (outst == '0) begin
                    if (aborting || abort_req) begin
                        state_nxt    = IDLE;
                        aborting_nxt = 1'b0;
                    end else if (stage != S_LAST) begin
                        state_nxt = ISSUE;
                        s_nxt     = stage + 1'b1;
                        k_nxt     = '0;
                    end else begin
                        state_nxt = FIN;
                    end
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge nReset) begin
        if (nReset) begin
            state    <= IDLE;
            stage    <= '0;
            k        <= '0;
            outst    <= '0;
            err      <= 1'b0;
            aborting <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bf_valid <= 1'b0;
            addr_a   <= '0;
            addr_b   <= '0;
            tw_idx   <= '0;
        end else begin
            state    <= state_nxt;
            stage    <= s_nxt;
            k        <= k_nxt;
            outst    <= outst_nxt;
            err      <= err_nxt;
            aborting <= aborting_nxt;
            busy     <= (state_nxt != IDLE);
            done     <= (state_nxt == FIN);
            bf_valid <= (state_nxt == ISSUE) && (outst_nxt < OUTST_MAX);
            addr_a   <= a_nxt;
            addr_b   <= b_nxt;
            tw_idx   <= tw_nxt;
        end
    end

`ifdef FFT_SCHED_ABORT_EN
    // DRAIN only falls back to IDLE on the abort path.
    always_ff @(posedge Clock or posedge nReset) begin
        if (nReset) aborted <= 1'b0;
        else        aborted <= (state == DRAIN) && (state_nxt == IDLE);
    end
`endif

endmodule

// File: tb/tb_fft_stage_scheduler.sv
// Directed, table-driven bench for fft_stage_scheduler (LOG2N=3; MAX_OUTST=4 and 2 instances).
module tb_fft_stage_scheduler;

    logic       Clock;
    logic       nReset;

    logic       start4, ready4, bf_done4;
    logic       busy4, done4, err4, bf_valid4;
    logic [2:0] addr_a4, addr_b4;
    logic [1:0] tw4, stage4;

    logic       start2, ready2, bf_done2;
    logic       busy2, done2, err2, bf_valid2;
    logic [2:0] addr_a2, addr_b2;
    logic [1:0] tw2, stage2;

`ifdef FFT_SCHED_ABORT_EN
    logic abort4, aborted4, abort2, aborted2;
`endif

    fft_stage_scheduler #(.LOG2N(3), .MAX_OUTST(4)) dut4 (
        .Clock(Clock), .nReset(nReset), .start(start4), .busy(busy4), .done(done4),
        .err(err4), .bf_valid(bf_valid4), .bf_ready(ready4), .bf_done(bf_done4),
        .addr_a(addr_a4), .addr_b(addr_b4), .tw_idx(tw4), .stage(stage4)
`ifdef FFT_SCHED_ABORT_EN
        , .abort(abort4), .aborted(aborted4)
`endif
    );

    fft_stage_scheduler #(.LOG2N(3), .MAX_OUTST(2)) dut2 (
        .Clock(Clock), .nReset(nReset), .start(start2), .busy(busy2), .done(done2),
        .err(err2), .bf_valid(bf_valid2), .bf_ready(ready2), .bf_done(bf_done2),
        .addr_a(addr_a2), .addr_b(addr_b2), .tw_idx(tw2), .stage(stage2)
`ifdef FFT_SCHED_ABORT_EN
        , .abort(abort2), .aborted(aborted2)
`endif
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        int a;
        int b;
        int tw;
        int st;
    } vec_t;

    vec_t vecs[12];
    vec_t got[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // Full transform on dut4; bf_done returned 2 cycles after each issue.
    task automatic run4(input bit stall, input string tag);
        logic [2:0] pipe;
        int         ndone;
        int         stalls;
        bit         fin;
        got.delete();
        pipe   = '0;
        ndone  = 0;
        stalls = 0;
        fin    = 0;
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        chk({tag, " busy after start"}, int'(busy4), 1);
        chk({tag, " first valid"}, int'(bf_valid4), 1);
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            if (done4) begin
                ndone++;
                fin = 1;
            end
            ready4 = 1'b1;
            start4 = 1'b0;
            if (stall && stalls < 5 &&
                (stalls > 0 || (bf_valid4 && stage4 == 2'd1 && addr_a4 == 3'd1))) begin
                ready4 = 1'b0;
                stalls++;
                start4 = (stalls == 2);
                chk($sformatf("%s stall%0d valid", tag, stalls), int'(bf_valid4), 1);
                chk($sformatf("%s stall%0d addr_a", tag, stalls), int'(addr_a4), 1);
                chk($sformatf("%s stall%0d addr_b", tag, stalls), int'(addr_b4), 3);
                chk($sformatf("%s stall%0d tw", tag, stalls), int'(tw4), 2);
            end
            if (bf_valid4 && ready4)
                got.push_back('{int'(addr_a4), int'(addr_b4), int'(tw4), int'(stage4)});
            bf_done4 = pipe[1];
            pipe     = {pipe[1:0], bf_valid4 && ready4};
            step();
        end
        start4   = 1'b0;
        ready4   = 1'b0;
        bf_done4 = 1'b0;
        chk({tag, " completed"}, int'(fin), 1);
        chk({tag, " done pulses"}, ndone, 1);
        chk({tag, " done single"}, int'(done4), 0);
        chk({tag, " busy after done"}, int'(busy4), 0);
        chk({tag, " err"}, int'(err4), 0);
        if (stall) chk({tag, " stall cycles"}, stalls, 5);
        chk({tag, " issue count"}, got.size(), 12);
        for (int i = 0; i < 12; i++) begin
            if (i < got.size()) begin
                chk($sformatf("%s iss%0d addr_a", tag, i), got[i].a, vecs[i].a);
                chk($sformatf("%s iss%0d addr_b", tag, i), got[i].b, vecs[i].b);
                chk($sformatf("%s iss%0d tw", tag, i), got[i].tw, vecs[i].tw);
                chk($sformatf("%s iss%0d stage", tag, i), got[i].st, vecs[i].st);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         n;
        int         a3;
        int         b3;
        bit         seen;
        logic [2:0] pipe;

        vecs[0]  = '{0, 1, 0, 0}; vecs[1]  = '{2, 3, 0, 0};
        vecs[2]  = '{4, 5, 0, 0}; vecs[3]  = '{6, 7, 0, 0};
        vecs[4]  = '{0, 2, 0, 1}; vecs[5]  = '{1, 3, 2, 1};
        vecs[6]  = '{4, 6, 0, 1}; vecs[7]  = '{5, 7, 2, 1};
        vecs[8]  = '{0, 4, 0, 2}; vecs[9]  = '{1, 5, 1, 2};
        vecs[10] = '{2, 6, 2, 2}; vecs[11] = '{3, 7, 3, 2};

        nReset = 1'b1;
        start4 = 1'b0; ready4 = 1'b0; bf_done4 = 1'b0;
        start2 = 1'b0; ready2 = 1'b0; bf_done2 = 1'b0;
`ifdef FFT_SCHED_ABORT_EN
        abort4 = 1'b0; abort2 = 1'b0;
`endif
        step();
        step();
        chk("rst busy", int'(busy4), 0);
        chk("rst done", int'(done4), 0);
        chk("rst err", int'(err4), 0);
        chk("rst valid", int'(bf_valid4), 0);
        chk("rst addr_a", int'(addr_a4), 0);
        chk("rst addr_b", int'(addr_b4), 0);
        chk("rst tw", int'(tw4), 0);
        chk("rst stage", int'(stage4), 0);
        nReset = 1'b0;
        step();

        run4(1'b0, "t1");
        run4(1'b1, "t2");

        // Spurious completion while idle sets the sticky error.
        bf_done4 = 1'b1;
        step();
        bf_done4 = 1'b0;
        chk("err set", int'(err4), 1);
        step();
        step();
        chk("err sticky", int'(err4), 1);
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        chk("err cleared by start", int'(err4), 0);

        // Last stage-0 completion withheld: no stage advance until it arrives.
        ready4 = 1'b1;
        pipe   = '0;
        n      = 0;
        for (int i = 0; i < 12; i++) begin
            bf_done4 = pipe[1];
            if (bf_valid4 && ready4) n++;
            pipe = {pipe[1:0], bf_valid4 && ready4 && n <= 3};
            step();
        end
        bf_done4 = 1'b0;
        ready4   = 1'b0;
        chk("t4 s0 issues", n, 4);
        chk("t4 stage held", int'(stage4), 0);
        chk("t4 valid low in drain", int'(bf_valid4), 0);
        chk("t4 busy", int'(busy4), 1);
        bf_done4 = 1'b1;
        step();
        bf_done4 = 1'b0;
        seen = 0;
        for (int i = 0; i < 6 && !seen; i++) begin
            if (bf_valid4) seen = 1;
            else step();
        end
        chk("t4 s1 valid", int'(seen), 1);
        chk("t4 s1 stage", int'(stage4), 1);
        chk("t4 s1 addr_a", int'(addr_a4), 0);
        chk("t4 s1 addr_b", int'(addr_b4), 2);

        // Outstanding limit on the MAX_OUTST=2 instance.
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        ready2 = 1'b1;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            if (bf_valid2 && ready2) n++;
            step();
        end
        chk("t3 issues at limit", n, 2);
        chk("t3 valid dropped", int'(bf_valid2), 0);
        bf_done2 = 1'b1;
        step();
        bf_done2 = 1'b0;
        n  = 0;
        a3 = -1;
        b3 = -1;
        for (int i = 0; i < 6; i++) begin
            if (bf_valid2 && ready2) begin
                n++;
                if (n == 1) begin
                    a3 = int'(addr_a2);
                    b3 = int'(addr_b2);
                end
            end
            step();
        end
        ready2 = 1'b0;
        chk("t3 issues after one done", n, 1);
        chk("t3 third addr_a", a3, 4);
        chk("t3 third addr_b", b3, 5);
        chk("t3 valid dropped again", int'(bf_valid2), 0);

        // Async reset mid stage 1 (dut4 holding request (0,2)).
        #2;
        nReset = 1'b1;
        #1;
        chk("t5 async valid", int'(bf_valid4), 0);
        chk("t5 async busy", int'(busy4), 0);
        chk("t5 async stage", int'(stage4), 0);
        chk("t5 async addr_b", int'(addr_b4), 0);
        chk("t5 async done", int'(done4), 0);
        step();
        nReset = 1'b0;
        step();
        chk("t5 no done after reset", int'(done4), 0);
        run4(1'b0, "t5");

`ifdef FFT_SCHED_ABORT_EN
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        pipe = '0;
        n    = 0;
        for (int i = 0; i < 100 && n < 2; i++) begin
            ready4   = 1'b1;
            bf_done4 = pipe[1];
            if (bf_valid4 && stage4 == 2'd1) n++;
            pipe = {pipe[1:0], bf_valid4 && stage4 == 2'd0};
            step();
        end
        bf_done4 = 1'b0;
        chk("t6 s1 issues before abort", n, 2);
        abort4 = 1'b1;
        ready4 = 1'b0;
        step();
        abort4 = 1'b0;
        ready4 = 1'b1;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            if (bf_valid4 && ready4) n++;
            step();
        end
        chk("t6 no issue after abort", n, 0);
        chk("t6 aborted early", int'(aborted4), 0);
        bf_done4 = 1'b1;
        step();
        step();
        bf_done4 = 1'b0;
        n = 0;
        a3 = 0;
        for (int i = 0; i < 6; i++) begin
            if (aborted4) n++;
            if (done4) a3++;
            step();
        end
        ready4 = 1'b0;
        chk("t6 aborted pulses", n, 1);
        chk("t6 done pulses", a3, 0);
        chk("t6 busy", int'(busy4), 0);
        chk("t6 err", int'(err4), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
